// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmit/receive blocks: parity encodings,
// frame state type, common bit-period constants and a frame-length helper.
package uart_pkg;

    localparam int PARITY_NONE = 0;
    localparam int PARITY_EVEN = 1;
    localparam int PARITY_ODD  = 2;

    // Clock cycles per bit for a 50 MHz system clock
    localparam int CLKS_9600_50MHZ   = 5208;
    localparam int CLKS_115200_50MHZ = 434;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } state_e;

    // Total clock cycles occupied by one frame on the line
    function automatic int frame_len(input int clks_per_bit, input int data_bits,
                                     input int parity_mode, input int stop_bits);
        return clks_per_bit * (1 + data_bits + ((parity_mode != PARITY_NONE) ? 1 : 0) + stop_bits);
    endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// Bit-period counter: counts 0..CLKS_PER_BIT-1 while running and flags the
// last cycle of each bit. Held at zero while cleared so a new frame always
// starts on a full bit period.
module uart_baud_tick
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = CLKS_9600_50MHZ
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic clear_i,
    input  logic run_i,
    output logic bit_end_o
);

    localparam int              CNT_W    = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // Next count: restart on clear, wrap at the end of each bit period
    always_comb begin
        cnt_d = cnt_q;
        if (clear_i) begin
            cnt_d = '0;
        end else if (run_i) begin
            cnt_d = (cnt_q == CNT_LAST) ? '0 : cnt_q + CNT_W'(1);
        end
    end

    // Counter register with synchronous active-low reset
    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign bit_end_o = run_i && !clear_i && (cnt_q == CNT_LAST);

endmodule

// File: rtl/uart_tx_frame.sv
// RS-232 frame transmitter with a one-entry holding register.
//
//   state     | meaning
//   ----------+-------------------------------------------------------------
//   ST_IDLE   | line idle; loads the holding register when it is full
//   ST_START  | start bit (low)
//   ST_DATA   | payload bits, LSB first
//   ST_PARITY | parity bit (only when parity is enabled)
//   ST_STOP   | stop bit(s) (high); chains straight into ST_START if a word waits
//
// The FSM runs one cycle ahead of the registered line outputs: TXD_o, busy_o
// and done_o are registered from the current state, so the line lags the
// state by exactly one cycle and no input reaches an output combinationally.
module uart_tx_frame
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = CLKS_9600_50MHZ,
    parameter int DATA_BITS    = 8,
    parameter int PARITY_MODE  = PARITY_NONE,
    parameter int STOP_BITS    = 1
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic [DATA_BITS-1:0] data_i,
    input  logic                 valid_i,
    output logic                 ready_o,
    output logic                 busy_o,
    output logic                 done_o,
    output logic                 TXD_o
);

    if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_bad_data_bits
        $error("uart_tx_frame: DATA_BITS must be in 5..9");
    end
    if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_stop_bits
        $error("uart_tx_frame: STOP_BITS must be 1 or 2");
    end
    if (PARITY_MODE < 0 || PARITY_MODE > 2) begin : g_bad_parity
        $error("uart_tx_frame: PARITY_MODE must be 0, 1 or 2");
    end
    if (CLKS_PER_BIT < 2) begin : g_bad_clks
        $error("uart_tx_frame: CLKS_PER_BIT must be 2 or more");
    end

    localparam logic [3:0] LAST_DATA = 4'(DATA_BITS - 1);
    localparam logic [3:0] LAST_STOP = 4'(STOP_BITS - 1);
    localparam logic       ODD_FLIP  = (PARITY_MODE == PARITY_ODD);

    state_e               state_q, state_d;
    logic [DATA_BITS-1:0] hold_q, hold_d;
    logic                 hold_full_q, hold_full_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic                 parity_q, parity_d;
    logic [3:0]           bit_idx_q, bit_idx_d;
    logic                 txd_q, txd_d;
    logic                 busy_q, busy_d;
    logic                 done_q, done_d;
    logic                 ready_q, ready_d;

    logic load;
    logic frame_end;
    logic bit_end;

    uart_baud_tick #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_baud (
        .clk_i    (clk_i),
        .rst_i    (rst_i),
        .clear_i  (state_q == ST_IDLE),
        .run_i    (state_q != ST_IDLE),
        .bit_end_o(bit_end)
    );

    // FSM sequencing, holding-register handshake and shift-register load
    always_comb begin
        state_d     = state_q;
        hold_d      = hold_q;
        hold_full_d = hold_full_q;
        shift_d     = shift_q;
        parity_d    = parity_q;
        bit_idx_d   = bit_idx_q;
        load        = 1'b0;
        frame_end   = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (hold_full_q) begin
                    load = 1'b1;
                end
            end
            ST_START: begin
                if (bit_end) begin
                    state_d   = ST_DATA;
                    bit_idx_d = '0;
                end
            end
            ST_DATA: begin
                if (bit_end) begin
                    shift_d = shift_q >> 1;
                    if (bit_idx_q == LAST_DATA) begin
                        bit_idx_d = '0;
                        state_d   = (PARITY_MODE == PARITY_NONE) ? ST_STOP : ST_PARITY;
                    end else begin
                        bit_idx_d = bit_idx_q + 4'd1;
                    end
                end
            end
            ST_PARITY: begin
                if (bit_end) begin
                    state_d   = ST_STOP;
                    bit_idx_d = '0;
                end
            end
            ST_STOP: begin
                if (bit_end) begin
                    if (bit_idx_q == LAST_STOP) begin
                        frame_end = 1'b1;
                        bit_idx_d = '0;
                        if (hold_full_q) begin
                            load = 1'b1;
                        end else begin
                            state_d = ST_IDLE;
                        end
                    end else begin
                        bit_idx_d = bit_idx_q + 4'd1;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (load) begin
            shift_d     = hold_q;
            parity_d    = (^hold_q) ^ ODD_FLIP;
            hold_full_d = 1'b0;
            bit_idx_d   = '0;
            state_d     = ST_START;
        end

        // ready_q is only high while the holding register is empty, so a
        // handshake can never coincide with a drain.
        if (valid_i && ready_q) begin
            hold_d      = data_i;
            hold_full_d = 1'b1;
        end
    end

    // Registered line outputs derived from the current state; ready drops on
    // the filling edge and returns one edge after the drain, i.e. together
    // with the start bit of the word it handed over.
    always_comb begin
        txd_d = 1'b1;
        case (state_q)
            ST_START:  txd_d = 1'b0;
            ST_DATA:   txd_d = shift_q[0];
            ST_PARITY: txd_d = parity_q;
            default:   txd_d = 1'b1;
        endcase
        busy_d  = (state_q != ST_IDLE);
        done_d  = frame_end;
        ready_d = !(hold_full_d || hold_full_q);
    end

    // State and output registers with synchronous active-low reset
    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            state_q     <= ST_IDLE;
            hold_q      <= '0;
            hold_full_q <= 1'b0;
            shift_q     <= '0;
            parity_q    <= 1'b0;
            bit_idx_q   <= '0;
            txd_q       <= 1'b1;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            ready_q     <= 1'b1;
        end else begin
            state_q     <= state_d;
            hold_q      <= hold_d;
            hold_full_q <= hold_full_d;
            shift_q     <= shift_d;
            parity_q    <= parity_d;
            bit_idx_q   <= bit_idx_d;
            txd_q       <= txd_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            ready_q     <= ready_d;
        end
    end

    assign TXD_o   = txd_q;
    assign busy_o  = busy_q;
    assign done_o  = done_q;
    assign ready_o = ready_q;

endmodule

// File: tb/tb_uart_tx_frame.sv
// Bench for uart_tx_frame: three instances (8E1, 8O2, 5N1, 4 clocks per bit)
// checked every cycle against a frame-timeline model, plus table vectors and
// hand-written corner sequences.
module tb_uart_tx_frame;

    localparam int CPB = 4;
    localparam int CFG_DB [3] = '{8, 8, 5};
    localparam int CFG_PM [3] = '{1, 2, 0};
    localparam int CFG_SB [3] = '{1, 2, 1};

    logic       clk;
    logic       rst_drv;
    logic       valid_drv;
    logic [8:0] data_drv;
    logic [2:0] valid_v, ready_v, busy_v, done_v, txd_v;
    int         sel;

    logic txd_s, busy_s, done_s, ready_s;

    int checks;
    int failures;
    int cyc;
    int line_end;
    int ready_low_until;
    int accepted;
    int done_cnt;
    bit exp_txd [int];
    bit exp_done [int];

    typedef struct packed {
        logic [1:0]  sel;
        logic [8:0]  data;
        logic [3:0]  nbits;
        logic [15:0] bits;
    } vec_t;

    vec_t vecs [6];

    assign valid_v[0] = valid_drv && (sel == 0);
    assign valid_v[1] = valid_drv && (sel == 1);
    assign valid_v[2] = valid_drv && (sel == 2);

    uart_tx_frame #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY_MODE(1), .STOP_BITS(1)) dut_a (
        .clk_i(clk), .rst_i(rst_drv), .data_i(data_drv[7:0]), .valid_i(valid_v[0]),
        .ready_o(ready_v[0]), .busy_o(busy_v[0]), .done_o(done_v[0]), .TXD_o(txd_v[0]));

    uart_tx_frame #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY_MODE(2), .STOP_BITS(2)) dut_b (
        .clk_i(clk), .rst_i(rst_drv), .data_i(data_drv[7:0]), .valid_i(valid_v[1]),
        .ready_o(ready_v[1]), .busy_o(busy_v[1]), .done_o(done_v[1]), .TXD_o(txd_v[1]));

    uart_tx_frame #(.CLKS_PER_BIT(CPB), .DATA_BITS(5), .PARITY_MODE(0), .STOP_BITS(1)) dut_c (
        .clk_i(clk), .rst_i(rst_drv), .data_i(data_drv[4:0]), .valid_i(valid_v[2]),
        .ready_o(ready_v[2]), .busy_o(busy_v[2]), .done_o(done_v[2]), .TXD_o(txd_v[2]));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [15:0] s2b(input string s);
        logic [15:0] b;
        b = '0;
        for (int i = 0; i < s.len(); i++) b[i] = (s.getc(i) == 8'h31);
        return b;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s cyc=%0d actual=%0d expected=%0d", name, cyc, act, exp);
        end
    endtask

    task automatic model_reset();
        exp_txd.delete();
        exp_done.delete();
        line_end        = -100;
        ready_low_until = -1;
    endtask

    // Word accepted at edge n: build its line levels and place them on the timeline
    task automatic model_accept(input int n, input logic [8:0] d);
        bit b[$];
        bit par;
        int start;
        par = 1'b0;
        b.push_back(1'b0);
        for (int i = 0; i < CFG_DB[sel]; i++) begin
            b.push_back(d[i]);
            par ^= d[i];
        end
        if (CFG_PM[sel] != 0) b.push_back((CFG_PM[sel] == 2) ? !par : par);
        for (int i = 0; i < CFG_SB[sel]; i++) b.push_back(1'b1);
        start = (n + 2 > line_end + 1) ? n + 2 : line_end + 1;
        for (int i = 0; i < b.size(); i++)
            for (int c = 0; c < CPB; c++) exp_txd[start + i * CPB + c] = b[i];
        line_end = start + b.size() * CPB - 1;
        exp_done[line_end] = 1'b1;
        ready_low_until    = start - 1;
        accepted++;
    endtask

    task automatic tick();
        bit hs, rs;
        bit eb;
        hs = valid_drv && ready_s && rst_drv;
        rs = !rst_drv;
        @(posedge clk);
        cyc++;
        if (rs) model_reset();
        else if (hs) model_accept(cyc, data_drv);
        #1;
        txd_s   = txd_v[sel];
        busy_s  = busy_v[sel];
        done_s  = done_v[sel];
        ready_s = ready_v[sel];
        if (done_s === 1'b1) done_cnt++;
        eb = exp_txd.exists(cyc);
        chk("txd",   txd_s,   eb ? exp_txd[cyc] : 1'b1);
        chk("busy",  busy_s,  eb);
        chk("done",  done_s,  exp_done.exists(cyc));
        chk("ready", ready_s, cyc > ready_low_until);
    endtask

    task automatic do_reset();
        valid_drv = 1'b0;
        rst_drv   = 1'b0;
        tick();
        tick();
        rst_drv = 1'b1;
        tick();
    endtask

    task automatic wait_ready(input int limit);
        int k;
        k = 0;
        while (ready_s !== 1'b1 && k < limit) begin
            tick();
            k++;
        end
        if (ready_s !== 1'b1) chk("wait_ready_timeout", 0, 1);
    endtask

    initial begin
        int n1, n2, acc3, d1, d2, gap, len, k;
        checks = 0; failures = 0; cyc = 0; accepted = 0; done_cnt = 0;
        sel = 0; rst_drv = 1'b0; valid_drv = 1'b0; data_drv = '0;
        model_reset();

        vecs[0] = '{2'd0, 9'h0A5, 4'd11, s2b("01010010101")};
        vecs[1] = '{2'd1, 9'h001, 4'd12, s2b("010000000011")};
        vecs[2] = '{2'd2, 9'h01F, 4'd7,  s2b("0111111")};
        vecs[3] = '{2'd0, 9'h03C, 4'd11, s2b("00011110001")};
        vecs[4] = '{2'd2, 9'h00A, 4'd7,  s2b("0010101")};
        vecs[5] = '{2'd1, 9'h0FF, 4'd12, s2b("011111111111")};

        // Table vectors: one frame each, line compared against the listed bits
        for (int v = 0; v < 6; v++) begin
            sel = int'(vecs[v].sel);
            do_reset();
            done_cnt  = 0;
            data_drv  = vecs[v].data;
            valid_drv = 1'b1;
            tick();
            valid_drv = 1'b0;
            data_drv  = 9'($urandom);
            tick();
            len = int'(vecs[v].nbits) * CPB;
            for (int j = 0; j < len; j++) begin
                tick();
                chk("vec_txd",  txd_s,  vecs[v].bits[j / CPB]);
                chk("vec_done", done_s, j == len - 1);
                if (j == 0) chk("vec_ready_restored", ready_s, 1);
            end
            tick();
            chk("vec_idle_after", busy_s, 0);
            chk("vec_done_count", done_cnt, 1);
        end

        // Back-to-back: 0x55 then 0x0F while the first frame is on the line
        sel = 0;
        do_reset();
        data_drv = 9'h055; valid_drv = 1'b1;
        tick();
        n1 = cyc; valid_drv = 1'b0;
        wait_ready(20);
        data_drv = 9'h00F; valid_drv = 1'b1;
        tick();
        valid_drv = 1'b0;
        k = 0; gap = 0; d1 = 0; d2 = 0;
        for (int i = 0; i < 150; i++) begin
            tick();
            if (cyc >= n1 + 2 && k < 2 && busy_s !== 1'b1) gap++;
            if (done_s === 1'b1) begin
                if (k == 0) d1 = cyc; else d2 = cyc;
                k++;
            end
        end
        chk("b2b_dones", k, 2);
        chk("b2b_first_done", d1, n1 + 45);
        chk("b2b_spacing", d2 - d1, 44);
        chk("b2b_busy_gap", gap, 0);

        // Full holding register: third word must wait for the first frame to end
        sel = 0;
        do_reset();
        done_cnt = 0; accepted = 0;
        data_drv = 9'h011; valid_drv = 1'b1;
        tick();
        n1 = cyc; valid_drv = 1'b0;
        wait_ready(20);
        data_drv = 9'h022; valid_drv = 1'b1;
        tick();
        n2 = cyc;
        chk("hold_full_ready", ready_s, 0);
        data_drv = 9'h033;
        k = 0;
        while (accepted < 3 && k < 200) begin
            tick();
            k++;
        end
        acc3 = cyc;
        valid_drv = 1'b0;
        chk("hold_third_accepted", accepted, 3);
        chk("hold_third_accept_cycle", acc3, n1 + 47);
        chk("hold_second_accept_cycle", n2, n1 + 3);
        for (int i = 0; i < 120; i++) tick();
        chk("hold_frames", done_cnt, 3);

        // Reset during data bit 3, then a clean frame of 0x3C
        sel = 0;
        do_reset();
        data_drv = 9'h0C3; valid_drv = 1'b1;
        tick();
        n1 = cyc; valid_drv = 1'b0;
        while (cyc < n1 + 19) tick();
        rst_drv = 1'b0;
        tick();
        chk("rst_txd",   txd_s,   1);
        chk("rst_busy",  busy_s,  0);
        chk("rst_ready", ready_s, 1);
        chk("rst_done",  done_s,  0);
        rst_drv = 1'b1;
        tick();
        done_cnt = 0;
        data_drv = 9'h03C; valid_drv = 1'b1;
        tick();
        valid_drv = 1'b0;
        for (int i = 0; i < 60; i++) tick();
        chk("rst_new_frame_done", done_cnt, 1);

        // Randomised traffic on each configuration
        for (int s = 0; s < 3; s++) begin
            sel = s;
            do_reset();
            for (int i = 0; i < 500; i++) begin
                valid_drv = ($urandom_range(0, 2) == 0);
                data_drv  = 9'($urandom);
                tick();
            end
            valid_drv = 1'b0;
            for (int i = 0; i < 150; i++) tick();
            chk("rand_drained", busy_s, 0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
